// File: rtl/yalu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, default width.
package yalu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_UNS = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/yalu_comb.sv
// Single-cycle ALU datapath. Shift ops pass A through so a zero-count shift
// can complete in one cycle; the multi-cycle shift lives in yalu_seq.
module yalu_comb
    import yalu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] z_o,
    output logic             ovf_o,
    output logic             ex_o
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             sa, sb;

    assign sum  = a_i + b_i;
    assign diff = a_i + ~b_i + WIDTH'(1);
    assign sa   = a_i[WIDTH-1];
    assign sb   = b_i[WIDTH-1];

    always_comb begin
        z_o   = a_i;
        ovf_o = 1'b0;
        ex_o  = 1'b0;
        case (op_i)
            OP_AND: z_o = a_i & b_i;
            OP_OR:  z_o = a_i | b_i;
            OP_ADD: begin
                z_o   = sum;
                ovf_o = (sa == sb) && (sum[WIDTH-1] != sa);
            end
            OP_SUB: begin
                z_o   = diff;
                ovf_o = (sa != sb) && (diff[WIDTH-1] != sa);
            end
            OP_SLT: begin
                // differing signs decide directly; otherwise the difference cannot overflow
                z_o    = '0;
                z_o[0] = (sa != sb) ? sa : diff[WIDTH-1];
            end
            OP_SLL, OP_SRL: z_o = a_i;
            default: begin
                z_o  = '0;
                ex_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/yalu_seq.sv
// Sequential ALU: ready/valid front end, bit-serial shifter and held result
// registers around the single-cycle yalu_comb datapath.
module yalu_seq
    import yalu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             ovf,
    output logic             ex
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, acc_sh;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, ex_q, ex_d;

    logic [WIDTH-1:0] c_z;
    logic             c_ovf, c_ex;
    logic             accept, is_shift;

    yalu_comb #(.WIDTH(WIDTH)) u_comb (
        .a_i   (a),
        .b_i   (b),
        .op_i  (op),
        .z_o   (c_z),
        .ovf_o (c_ovf),
        .ex_o  (c_ex)
    );

    assign in_ready = (state_q == IDLE) || (state_q == HOLD && out_ready);
    assign accept   = in_valid && in_ready;
    assign is_shift = (op == OP_SLL) || (op == OP_SRL);
    assign acc_sh   = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        z_d     = z_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        ex_d    = ex_q;

        case (state_q)
            SHIFT: begin
                acc_d = acc_sh;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = HOLD;
                    z_d     = acc_sh;
                    zero_d  = (acc_sh == '0);
                    ovf_d   = 1'b0;
                    ex_d    = 1'b0;
                end
            end
            HOLD:    if (out_ready) state_d = IDLE;
            default: ;
        endcase

        // a fresh beat overrides the HOLD->IDLE drain so results can stream
        if (accept) begin
            if (is_shift && b[SHW-1:0] != '0) begin
                state_d = SHIFT;
                acc_d   = a;
                cnt_d   = b[SHW-1:0];
                left_d  = (op == OP_SLL);
            end else begin
                state_d = HOLD;
                z_d     = c_z;
                zero_d  = (c_z == '0);
                ovf_d   = c_ovf;
                ex_d    = c_ex;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ex_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            ex_q    <= ex_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign z         = z_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign ex        = ex_q;

endmodule

// File: tb/tb_yalu_seq.sv
// Bench for yalu_seq at WIDTH 8/32/64: per-width behavioural model with a
// per-cycle compare, plus literal directed checks on the 32-bit instance.
`timescale 1ns/1ps
module tb_yalu_seq;

    localparam int NBEATS = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W   = (gi == 0) ? 8 : (gi == 1) ? 32 : 64;
        localparam int SHW = $clog2(W);

        logic         rst = 1'b1, iv = 1'b0, ordy = 1'b0;
        logic         ir, ov, zr, of, ex;
        logic [2:0]   op = 3'd0;
        logic [W-1:0] a = '0, b = '0, z;

        yalu_seq #(.WIDTH(W)) u_dut (
            .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir),
            .a(a), .b(b), .op(op), .out_valid(ov), .out_ready(ordy),
            .z(z), .zero(zr), .ovf(of), .ex(ex)
        );

        // model: m_busy = cycles of shift left, m_valid = result held
        bit           m_valid = 1'b0;
        int           m_busy  = 0;
        int           m_acc   = 0;
        logic [W+2:0] m_res   = '0;
        bit           chk_en  = 1'b0;
        logic         m_rdy;
        assign m_rdy = (m_busy == 0 && !m_valid) || (m_valid && ordy);

        function automatic logic [W+2:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
            logic signed [W:0] s;
            logic [W-1:0] r;
            logic v, e;
            r = '0; v = 1'b0; e = 1'b0;
            case (o)
                3'd0: r = x & y;
                3'd1: r = x | y;
                3'd2: begin s = $signed({x[W-1], x}) + $signed({y[W-1], y}); r = s[W-1:0]; v = s[W] != s[W-1]; end
                3'd6: begin s = $signed({x[W-1], x}) - $signed({y[W-1], y}); r = s[W-1:0]; v = s[W] != s[W-1]; end
                3'd3: r = x << y[SHW-1:0];
                3'd4: r = x >> y[SHW-1:0];
                3'd7: r = ($signed(x) < $signed(y)) ? W'(1) : '0;
                default: e = 1'b1;
            endcase
            return {r, (r == '0), v, e};
        endfunction

        always @(posedge clk) begin : model
            bit           nv;
            int           nb;
            logic [W+2:0] nr;
            nv = m_valid; nb = m_busy; nr = m_res;
            if (rst) begin
                nv = 1'b0; nb = 0;
            end else begin
                if (m_valid && ordy) nv = 1'b0;
                if (m_busy > 0) begin
                    nb = m_busy - 1;
                    if (nb == 0) nv = 1'b1;
                end
                if (iv && m_rdy) begin
                    nr = ref_op(op, a, b);
                    m_acc <= m_acc + 1;
                    if ((op == 3'd3 || op == 3'd4) && b[SHW-1:0] != '0) begin
                        nb = int'(b[SHW-1:0]); nv = 1'b0;
                    end else nv = 1'b1;
                end
            end
            m_valid <= nv; m_busy <= nb; m_res <= nr;
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk($sformatf("w%0d_handshake", W), {ov, ir}, {m_valid, m_rdy});
                if (m_valid) chk($sformatf("w%0d_result", W), {z, zr, of, ex}, m_res);
            end
        end

        task automatic step();
            @(posedge clk); #1;
        endtask

        task automatic drv(input bit v, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit r);
            iv = v; op = o; a = x; b = y; ordy = r;
        endtask

        task automatic do_reset();
            rst = 1'b1; iv = 1'b0; ordy = 1'b1;
            step(); step();
            chk($sformatf("w%0d_rst_state", W), {ov, z, zr, of, ex}, '0);
            rst = 1'b0; #1;
            chk($sformatf("w%0d_rst_ready", W), ir, 1'b1);
            chk_en = 1'b1;
        endtask

        task automatic run_rand(input int n);
            int cyc = 0;
            while (m_acc < n && cyc < 40000) begin
                logic [127:0] ra, rb;
                ra = {$urandom, $urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom, $urandom};
                rst  = ($urandom_range(0, 599) == 0);
                iv   = ($urandom_range(0, 3) != 0);
                op   = 3'($urandom_range(0, 7));
                a    = W'(ra);
                b    = W'(rb);
                if ($urandom_range(0, 7) == 0) b[SHW-1:0] = '0;
                ordy = ($urandom_range(0, 3) != 0);
                step(); cyc++;
            end
            chk($sformatf("w%0d_beats_done", W), m_acc >= n, 1'b1);
            rst = 1'b0; iv = 1'b0; ordy = 1'b1;
            repeat (W + 4) step();
        endtask

        if (gi == 1) begin : g_dir
            initial begin
                int cyc;
                logic [31:0] x, y;
                do_reset();
                chk("model_add", ref_op(3'd2, 32'h7FFFFFFF, 32'd1), {32'h80000000, 3'b010});
                chk("model_slt", ref_op(3'd7, 32'hFFFFFFFF, 32'd1), {32'h00000001, 3'b000});
                chk("model_srl", ref_op(3'd4, 32'h80000000, 32'd31), {32'h00000001, 3'b000});

                drv(1, 3'd2, 32'h7FFFFFFF, 32'd1, 1); step(); iv = 0;
                chk("add_ovf", {ov, z, zr, of, ex}, {1'b1, 32'h80000000, 3'b010}); step();
                drv(1, 3'd6, 32'd5, 32'd5, 1); step(); iv = 0;
                chk("sub_zero", {z, zr, of, ex}, {32'h0, 3'b100}); step();
                drv(1, 3'd7, 32'hFFFFFFFF, 32'd1, 1); step(); iv = 0;
                chk("slt_neg", z, 32'd1); step();
                drv(1, 3'd7, 32'd1, 32'hFFFFFFFF, 1); step(); iv = 0;
                chk("slt_pos", {z, zr}, {32'h0, 1'b1}); step();

                drv(1, 3'd3, 32'd1, 32'h24, 1); step(); iv = 0;
                for (int i = 0; i < 4; i++) begin
                    chk("sll_busy", {ir, ov}, 2'b00); step();
                end
                chk("sll_done", {ov, z}, {1'b1, 32'h10}); step();

                drv(1, 3'd4, 32'h80000000, 32'd31, 1); step(); iv = 0;
                cyc = 1;
                while (!ov && cyc < 40) begin step(); cyc++; end
                chk("srl_latency", cyc, 32);
                chk("srl_z", z, 32'd1); step();

                for (int k = 0; k < 3; k++) begin
                    x = 32'hA5A50F0F + k * 32'h0101;
                    y = 32'hFFFF00FF - k;
                    drv(1, 3'd0, x, y, 1); step();
                    chk("b2b_and", {ov, z}, {1'b1, x & y});
                end
                iv = 0; step();
                chk("b2b_idle", ov, 1'b0);

                drv(1, 3'd0, 32'h0000FFFF, 32'h00FF00FF, 0); step();
                drv(1, 3'd1, 32'h12, 32'h34, 0);
                for (int i = 0; i < 3; i++) begin
                    chk("stall_hold", {ir, ov, z}, {2'b01, 32'h000000FF}); step();
                end
                ordy = 1; #1;
                chk("stall_release", ir, 1'b1);
                step(); iv = 0;
                chk("stall_next", {ov, z}, {1'b1, 32'h36}); step();

                drv(1, 3'd3, 32'd1, 32'd20, 1); step(); iv = 0;
                repeat (5) step();
                rst = 1; step();
                chk("rst_mid_shift", {ov, z}, {1'b0, 32'h0});
                rst = 0; #1;
                chk("rst_mid_ready", ir, 1'b1);
                drv(1, 3'd1, 32'hF0, 32'h0F, 1); step(); iv = 0;
                chk("or_after_rst", {ov, z}, {1'b1, 32'hFF}); step();
                drv(1, 3'd5, 32'h1234, 32'h5678, 1); step(); iv = 0;
                chk("unsupported", {ov, z, zr, of, ex}, {1'b1, 32'h0, 3'b101}); step();

                run_rand(NBEATS);
                done[gi] = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                run_rand(NBEATS);
                done[gi] = 1'b1;
            end
        end
    end

    initial begin
        for (int c = 0; c < 60000; c++) begin
            @(posedge clk);
            if (done[0] && done[1] && done[2]) break;
        end
        chk("all_done", {done[0], done[1], done[2]}, 3'b111);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
